uart_bus_slave: RTL and testbench

//  Memory-mapped UART peripheral answering the CPU's lw/sw at 0x40000018..0x40000020.

---
 rtl/uart_bus_slave_pkg.sv | 16 +
 rtl/uart_bus_slave_if.sv | 11 +
 rtl/uart_rx_engine.sv | 74 +++++++
 rtl/uart_bus_slave.sv | 123 ++++++++++++
 tb/tb_uart_bus_slave.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_bus_slave_pkg.sv
// rtl/uart_bus_slave_pkg.sv - shared offsets, status bit indices and FSM encodings
package uart_bus_slave_pkg;

    localparam logic [31:0] OFF_TX_DATA = 32'h0;
    localparam logic [31:0] OFF_RX_DATA = 32'h4;
    localparam logic [31:0] OFF_CTRL    = 32'h8;

    localparam int STAT_RX_READY  = 3;
    localparam int STAT_TX_BUSY   = 4;
    localparam int STAT_FRAME_ERR = 5;
    localparam int STAT_OVERRUN   = 6;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_bus_slave_if.sv
// rtl/uart_bus_slave_if.sv - CPU peripheral bus (load/store strobes, address, data)
interface uart_bus_slave_if;
    logic [31:0] addr;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output MemRead, output MemWrite, output wdata, input rdata);
    modport slave  (input addr, input MemRead, input MemWrite, input wdata, output rdata);
endinterface

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - synchronised 8N1 receiver producing byte_valid / frame_err pulses
module uart_rx_engine
    import uart_bus_slave_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       rxd,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] rx_data
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1, sync2, sync_prev;
    logic          fall;
    rx_state_t     state, state_next;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;

    assign fall    = sync_prev & ~sync2;
    assign rx_data = shift;

    // Next-state: start bit re-checked at its midpoint, then one sample per bit period
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (rx_en && fall) state_next = RX_START;
            RX_START: if (cnt == HALF_END) state_next = sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt == BIT_END && idx == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (cnt == BIT_END) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    // Synchroniser, state register, bit timer, LSB-first shifter and result pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            sync_prev  <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rxd;
            sync2      <= sync1;
            sync_prev  <= sync2;
            state      <= state_next;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == RX_IDLE || state_next != state || cnt == BIT_END)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == RX_DATA && cnt == BIT_END) begin
                shift <= {sync2, shift[7:1]};
                idx   <= idx + 1'b1;
            end
            if (state == RX_STOP && cnt == BIT_END) begin
                if (sync2) byte_valid <= 1'b1;
                else       frame_err  <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_bus_slave.sv
// rtl/uart_bus_slave.sv - memory-mapped UART: register file, address decode and TX FSM
module uart_bus_slave
    import uart_bus_slave_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 10417,
    parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
    input  logic              clk,
    input  logic              reset,
    uart_bus_slave_if.slave   bus,
    input  logic              uart_rxd,
    output logic              uart_txd,
    output logic              rx_irq
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

    logic          sel_tx, sel_rx, sel_ctrl;
    logic          tx_accept, tx_busy, tx_bit_end;
    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;
    logic [1:0]    ctrl;
    logic [7:0]    rx_byte;
    logic          rx_ready, frame_err, overrun;
    logic          rx_valid, rx_ferr;
    logic [7:0]    rx_data;
    logic          unused_wdata;

    assign unused_wdata = &{1'b0, bus.wdata[31:8]};

    assign sel_tx     = (bus.addr == BASE_ADDR + OFF_TX_DATA);
    assign sel_rx     = (bus.addr == BASE_ADDR + OFF_RX_DATA);
    assign sel_ctrl   = (bus.addr == BASE_ADDR + OFF_CTRL);
    assign tx_busy    = (tx_state != TX_IDLE);
    assign tx_bit_end = (tx_cnt == BIT_END);
    assign tx_accept  = sel_tx & bus.MemWrite & ctrl[0] & ~tx_busy;
    assign rx_irq     = rx_ready & ctrl[1];

    uart_rx_engine #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx_en      (ctrl[1]),
        .rxd        (uart_rxd),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr),
        .rx_data    (rx_data)
    );

    // TX next-state and line level; ctrl[0] only gates the start of a frame
    always_comb begin
        tx_next  = tx_state;
        uart_txd = 1'b1;
        case (tx_state)
            TX_IDLE:  if (tx_accept) tx_next = TX_START;
            TX_START: begin
                uart_txd = 1'b0;
                if (tx_bit_end) tx_next = TX_DATA;
            end
            TX_DATA:  begin
                uart_txd = tx_shift[0];
                if (tx_bit_end && tx_idx == 3'd7) tx_next = TX_STOP;
            end
            TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX state register, bit timer and shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_IDLE || tx_bit_end) tx_cnt <= '0;
            else                                   tx_cnt <= tx_cnt + 1'b1;
            if (tx_accept) begin
                tx_shift <= bus.wdata[7:0];
            end else if (tx_state == TX_DATA && tx_bit_end) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_idx   <= tx_idx + 1'b1;
            end
        end
    end

    // Control and sticky status; a set from the receiver wins over a read-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl      <= '0;
            rx_byte   <= '0;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (sel_ctrl && bus.MemWrite) ctrl <= bus.wdata[1:0];
            if (rx_valid) rx_byte <= rx_data;
            if (rx_valid)                      rx_ready <= 1'b1;
            else if (sel_rx && bus.MemRead)    rx_ready <= 1'b0;
            if (rx_valid && rx_ready)          overrun <= 1'b1;
            else if (sel_ctrl && bus.MemRead)  overrun <= 1'b0;
            if (rx_ferr)                       frame_err <= 1'b1;
            else if (sel_ctrl && bus.MemRead)  frame_err <= 1'b0;
        end
    end

    // Read mux: combinational from address, zero when nothing readable is selected
    always_comb begin
        bus.rdata = '0;
        if (sel_rx) begin
            bus.rdata[7:0] = rx_byte;
        end else if (sel_ctrl) begin
            bus.rdata[1:0]            = ctrl;
            bus.rdata[STAT_RX_READY]  = rx_ready;
            bus.rdata[STAT_TX_BUSY]   = tx_busy;
            bus.rdata[STAT_FRAME_ERR] = frame_err;
            bus.rdata[STAT_OVERRUN]   = overrun;
        end
    end
endmodule

// File: tb/tb_uart_bus_slave.sv
// tb/tb_uart_bus_slave.sv - directed self-checking bench for uart_bus_slave
module tb_uart_bus_slave;
    localparam int          CPB    = 16;
    localparam logic [31:0] A_TX   = 32'h40000018;
    localparam logic [31:0] A_RX   = 32'h4000001C;
    localparam logic [31:0] A_CTRL = 32'h40000020;

    logic clk = 1'b0;
    logic reset;
    logic uart_rxd;
    logic uart_txd;
    logic rx_irq;
    int   tests = 0;
    int   fails = 0;

    uart_bus_slave_if bus_if();

    uart_bus_slave #(.CLKS_PER_BIT(CPB), .BASE_ADDR(A_TX)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .rx_irq   (rx_irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus_if.addr = a;
        #1;
        d = bus_if.rdata;
        bus_if.addr = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.addr     = a;
        bus_if.wdata    = d;
        bus_if.MemWrite = 1'b1;
        tick(1);
        bus_if.MemWrite = 1'b0;
        bus_if.addr     = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_if.addr    = a;
        bus_if.MemRead = 1'b1;
        #1;
        d = bus_if.rdata;
        tick(1);
        bus_if.MemRead = 1'b0;
        bus_if.addr    = '0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            tick(CPB);
        end
        uart_rxd = stop;
        tick(CPB);
        uart_rxd = 1'b1;
    endtask

    // Checks one whole TX frame cycle by cycle; optional store attempts at rej_a / rej_b
    task automatic run_tx_frame(input logic [7:0] b, input int rej_a, input int rej_b);
        logic [31:0] s;
        logic        exp;
        for (int i = 0; i < 10 * CPB; i++) begin
            exp = (i < CPB) ? 1'b0 : (i < 9 * CPB) ? b[(i - CPB) / CPB] : 1'b1;
            tests++;
            if (uart_txd !== exp) begin
                fails++;
                $display("FAIL tx_line cycle %0d: got %b expected %b", i, uart_txd, exp);
            end
            peek(A_CTRL, s);
            tests++;
            if (s[4] !== 1'b1) begin
                fails++;
                $display("FAIL tx_busy cycle %0d: got %b expected 1", i, s[4]);
            end
            if (i == rej_a || i == rej_b) begin
                bus_if.addr     = A_TX;
                bus_if.wdata    = 32'h3C;
                bus_if.MemWrite = 1'b1;
            end
            tick(1);
            bus_if.MemWrite = 1'b0;
            bus_if.addr     = '0;
        end
        for (int i = 0; i < 30; i++) begin
            peek(A_CTRL, s);
            tests++;
            if (uart_txd !== 1'b1 || s[4] !== 1'b0) begin
                fails++;
                $display("FAIL tx_idle_after cycle %0d: got txd=%b busy=%b expected txd=1 busy=0", i, uart_txd, s[4]);
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        tick(3);
        tests++;
        if (uart_txd !== 1'b1 || rx_irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got txd=%b irq=%b expected txd=1 irq=0", uart_txd, rx_irq);
        end
        reset = 1'b0;
        tick(1);
        peek(A_CTRL, d);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_stat: got %h expected 00000000", d); end
        peek(A_RX, d);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_rxdata: got %h expected 00000000", d); end
    endtask

    task automatic test_tx();
        logic [31:0] d;
        bus_write(A_CTRL, 32'h3);
        peek(A_CTRL, d);
        tests++;
        if (d !== 32'h3) begin fails++; $display("FAIL ctrl_write: got %h expected 00000003", d); end
        peek(A_TX, d);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL txdata_read: got %h expected 00000000", d); end
        peek(32'h40000024, d);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL unselected_hi: got %h expected 00000000", d); end
        peek(32'h50000020, d);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL unselected_alias: got %h expected 00000000", d); end
        bus_write(A_TX, 32'hFFFF_FFA5);
        run_tx_frame(8'hA5, -1, -1);
    endtask

    task automatic test_busy_reject();
        bus_write(A_TX, 32'hA5);
        run_tx_frame(8'hA5, 40, 10 * CPB - 1);
    endtask

    task automatic test_rx_basic();
        logic [31:0] d;
        send_rx(8'h5A, 1'b1);
        tick(4);
        peek(A_CTRL, d);
        tests++;
        if (d !== 32'h0B) begin fails++; $display("FAIL rx_stat_ready: got %h expected 0000000b", d); end
        tests++;
        if (rx_irq !== 1'b1) begin fails++; $display("FAIL rx_irq_set: got %b expected 1", rx_irq); end
        bus_read(A_RX, d);
        tests++;
        if (d !== 32'h5A) begin fails++; $display("FAIL rx_data: got %h expected 0000005a", d); end
        peek(A_CTRL, d);
        tests++;
        if (d !== 32'h03) begin fails++; $display("FAIL rx_stat_cleared: got %h expected 00000003", d); end
        tests++;
        if (rx_irq !== 1'b0) begin fails++; $display("FAIL rx_irq_clear: got %b expected 0", rx_irq); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        tick(4);
        peek(A_RX, d);
        tests++;
        if (d !== 32'h22) begin fails++; $display("FAIL overrun_data: got %h expected 00000022", d); end
        bus_read(A_CTRL, d);
        tests++;
        if (d !== 32'h4B) begin fails++; $display("FAIL overrun_stat: got %h expected 0000004b", d); end
        bus_read(A_CTRL, d);
        tests++;
        if (d !== 32'h0B) begin fails++; $display("FAIL overrun_cleared: got %h expected 0000000b", d); end
        bus_read(A_RX, d);
        peek(A_CTRL, d);
        tests++;
        if (d !== 32'h03) begin fails++; $display("FAIL overrun_drain: got %h expected 00000003", d); end
    endtask

    task automatic test_frame_err_glitch();
        logic [31:0] d;
        send_rx(8'h77, 1'b0);
        tick(4);
        bus_read(A_CTRL, d);
        tests++;
        if (d !== 32'h23) begin fails++; $display("FAIL frame_err_stat: got %h expected 00000023", d); end
        peek(A_CTRL, d);
        tests++;
        if (d !== 32'h03) begin fails++; $display("FAIL frame_err_clear: got %h expected 00000003", d); end
        uart_rxd = 1'b0;
        tick(CPB / 2);
        uart_rxd = 1'b1;
        tick(12 * CPB);
        peek(A_CTRL, d);
        tests++;
        if (d !== 32'h03) begin fails++; $display("FAIL glitch_stat: got %h expected 00000003", d); end
        peek(A_RX, d);
        tests++;
        if (d !== 32'h22) begin fails++; $display("FAIL glitch_data: got %h expected 00000022", d); end
    endtask

    task automatic test_rx_disabled();
        logic [31:0] d;
        bus_write(A_CTRL, 32'h1);
        send_rx(8'h33, 1'b1);
        tick(4);
        peek(A_CTRL, d);
        tests++;
        if (d !== 32'h01) begin fails++; $display("FAIL rx_disabled_stat: got %h expected 00000001", d); end
        bus_write(A_CTRL, 32'h3);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        bus_write(A_TX, 32'hA5);
        tick(CPB + 4 * CPB + CPB / 2);
        tests++;
        if (uart_txd !== 1'b0) begin fails++; $display("FAIL tx_bit4_before_reset: got %b expected 0", uart_txd); end
        reset = 1'b1;
        tick(1);
        tests++;
        if (uart_txd !== 1'b1) begin fails++; $display("FAIL reset_mid_txd: got %b expected 1", uart_txd); end
        reset = 1'b0;
        peek(A_CTRL, d);
        tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_mid_stat: got %h expected 00000000", d); end
        bus_write(A_TX, 32'h3C);
        for (int i = 0; i < 30; i++) begin
            peek(A_CTRL, d);
            tests++;
            if (uart_txd !== 1'b1 || d !== 32'h0) begin
                fails++;
                $display("FAIL tx_disabled cycle %0d: got txd=%b stat=%h expected txd=1 stat=00000000", i, uart_txd, d);
            end
            tick(1);
        end
    endtask

    initial begin
        reset           = 1'b1;
        uart_rxd        = 1'b1;
        bus_if.addr     = '0;
        bus_if.wdata    = '0;
        bus_if.MemRead  = 1'b0;
        bus_if.MemWrite = 1'b0;
        tick(1);
        test_reset();
        test_tx();
        test_busy_reject();
        test_rx_basic();
        test_overrun();
        test_frame_err_glitch();
        test_rx_disabled();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
